// File: rtl/axi4lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_pkg
// Shared definitions for the AXI4-Lite CLINT timer block: register offsets,
// AXI response codes, channel FSM state encodings, register selector, and the
// helpers used for address qualification and byte-lane write merging.
// -----------------------------------------------------------------------------
package axi4lite_pkg;

  localparam logic [3:0] OFF_MTIME_LO    = 4'h0;
  localparam logic [3:0] OFF_MTIME_HI    = 4'h4;
  localparam logic [3:0] OFF_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] OFF_MTIMECMP_HI = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} rd_state_e;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;

  // Word index of a register, i.e. offset[3:2].
  typedef enum logic [1:0] {
    REG_MTIME_LO    = OFF_MTIME_LO[3:2],
    REG_MTIME_HI    = OFF_MTIME_HI[3:2],
    REG_MTIMECMP_LO = OFF_MTIMECMP_LO[3:2],
    REG_MTIMECMP_HI = OFF_MTIMECMP_HI[3:2]
  } reg_sel_e;

  // The crossbar hands this block a window-relative address, so anything past
  // the 16-byte register file, or not word aligned, is unmapped.
  function automatic logic addr_mapped(input logic [31:0] addr);
    return (addr[31:4] == 28'd0) && (addr[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return merged;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
// Prescaled 64-bit mtime counter, 64-bit mtimecmp compare register and the
// registered timer interrupt. A single-cycle write port (already qualified by
// the bus side) updates one 32-bit half with byte-lane merging.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   wr_en                 commit a write this cycle
//   wr_sel                which 32-bit register half to write
//   wr_data, wr_strb      write data and byte-lane strobes
//   mtime, mtimecmp       current register values
//   timer_irq             registered (mtime >= mtimecmp), one-cycle lag
// -----------------------------------------------------------------------------
module clint_timer
  import axi4lite_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  reg_sel_e    wr_sel,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timer_irq
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [15:0] prescaler;
  logic        tick;

  // With TICK_DIV == 1 the prescaler sits at 0 and every cycle is a tick.
  assign tick = (prescaler == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples pre-edge values, which the one-cycle irq lag relies on.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 16'd1;
      timer_irq <= (mtime >= mtimecmp);

      // A bus write to either mtime half wins over the tick for that cycle.
      if (wr_en && wr_sel == REG_MTIME_LO)
        mtime <= {mtime[63:32], merge_bytes(mtime[31:0], wr_data, wr_strb)};
      else if (wr_en && wr_sel == REG_MTIME_HI)
        mtime <= {merge_bytes(mtime[63:32], wr_data, wr_strb), mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'd1;

      if (wr_en && wr_sel == REG_MTIMECMP_LO)
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wr_data, wr_strb);
      if (wr_en && wr_sel == REG_MTIMECMP_HI)
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wr_data, wr_strb);
    end
  end

endmodule

// File: rtl/axi4lite_clint.sv
// -----------------------------------------------------------------------------
// axi4lite_clint
// AXI4-Lite slave front end for the CLINT machine timer. Independent read and
// write channel FSMs; the timer itself lives in clint_timer.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   arvalid/araddr/arready        read address channel
//   rvalid/rdata/rresp/rready     read data channel
//   awvalid/awaddr/awready        write address channel
//   wvalid/wdata/wstrb/wready     write data channel
//   bvalid/bresp/bready           write response channel
//   timer_irq                     machine timer interrupt
// -----------------------------------------------------------------------------
module axi4lite_clint
  import axi4lite_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  output logic        arready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        rready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  output logic        awready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        wready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  input  logic        bready,
  output logic        timer_irq
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] hi_snap;

  rd_state_e   r_state;
  wr_state_e   w_state;

  logic        aw_held;
  logic        aw_ok_q;
  reg_sel_e    aw_sel_q;
  logic        w_held;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic        commit;
  logic        wr_en;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);
  assign awready = !aw_held;
  assign wready  = !w_held;
  assign bvalid  = (w_state == W_RESP);

  assign commit = (w_state == W_IDLE) && aw_held && w_held;
  // An all-zero strobe completes OKAY but touches nothing, so it must not
  // steal the mtime increment either.
  assign wr_en  = commit && aw_ok_q && (w_strb_q != 4'h0);

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (aw_sel_q),
    .wr_data   (w_data_q),
    .wr_strb   (w_strb_q),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .timer_irq (timer_irq)
  );

  // Read channel. Data is captured from pre-edge values at the AR handshake,
  // so a same-cycle write to the same register returns the old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      hi_snap <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_state <= R_RESP;
          if (!addr_mapped(araddr)) begin
            rdata <= '0;
            rresp <= RESP_SLVERR;
          end else begin
            rresp <= RESP_OKAY;
            case (reg_sel_e'(araddr[3:2]))
              // Snapshot the upper half so a lo-then-hi read pair is coherent.
              REG_MTIME_LO: begin
                rdata   <= mtime[31:0];
                hi_snap <= mtime[63:32];
              end
              REG_MTIME_HI:    rdata <= hi_snap;
              REG_MTIMECMP_LO: rdata <= mtimecmp[31:0];
              REG_MTIMECMP_HI: rdata <= mtimecmp[63:32];
            endcase
          end
        end
        R_RESP: if (rready) r_state <= R_IDLE;
      endcase
    end
  end

  // Write channel. AW and W are parked independently; the commit happens on
  // the first edge that sees both held, and that same edge enters W_RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      aw_ok_q  <= 1'b0;
      aw_sel_q <= REG_MTIME_LO;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && !aw_held) begin
            aw_held  <= 1'b1;
            aw_ok_q  <= addr_mapped(awaddr);
            aw_sel_q <= reg_sel_e'(awaddr[3:2]);
          end
          if (wvalid && !w_held) begin
            w_held   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
          end
          if (commit) begin
            w_state <= W_RESP;
            bresp   <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_RESP: if (bready) begin
          w_state <= W_IDLE;
          aw_held <= 1'b0;
          w_held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_clint.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_clint
// Directed bench for axi4lite_clint. u_dut runs with TICK_DIV=1, u_dut4 with
// TICK_DIV=4. Inputs change and outputs are sampled on the falling edge.
// The bench keeps its own mtime/mtimecmp/hi_snap model driven only by the
// stimulus it issues and the edge numbers at which handshakes occur.
// -----------------------------------------------------------------------------
module tb_axi4lite_clint;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // TICK_DIV = 1 instance
  logic        rst, arvalid, rready, awvalid, wvalid, bready;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arready, rvalid, awready, wready, bvalid, timer_irq;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  // TICK_DIV = 4 instance
  logic        rst4, arvalid4, rready4, awvalid4, wvalid4, bready4;
  logic [31:0] araddr4, awaddr4, wdata4;
  logic [3:0]  wstrb4;
  logic        arready4, rvalid4, awready4, wready4, bvalid4, timer_irq4;
  logic [31:0] rdata4;
  logic [1:0]  rresp4, bresp4;

  axi4lite_clint #(.TICK_DIV(1)) u_dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .timer_irq(timer_irq)
  );

  axi4lite_clint #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .arvalid(arvalid4), .araddr(araddr4), .arready(arready4),
    .rvalid(rvalid4), .rdata(rdata4), .rresp(rresp4), .rready(rready4),
    .awvalid(awvalid4), .awaddr(awaddr4), .awready(awready4),
    .wvalid(wvalid4), .wdata(wdata4), .wstrb(wstrb4), .wready(wready4),
    .bvalid(bvalid4), .bresp(bresp4), .bready(bready4),
    .timer_irq(timer_irq4)
  );

  // Model state: mtime after edge n is m_base + (n - m_cyc) for the
  // TICK_DIV=1 instance; for the TICK_DIV=4 instance it is (n - base4) / 4.
  logic [63:0] m_base;
  int          m_cyc;
  logic [63:0] m_cmp;
  logic [31:0] m_snap;
  int          base4;

  function automatic logic [63:0] exp_mtime(input int n);
    return m_base + 64'(n - m_cyc);
  endfunction

  function automatic logic [31:0] exp4(input int n);
    return 32'((n - base4) / 4);
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Apply a write committed at edge c to the model.
  task automatic note_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int c);
    logic [63:0] cur;
    if (a[31:4] == 28'd0 && a[1:0] == 2'b00 && s != 4'h0) begin
      cur = exp_mtime(c - 1);
      case (a[3:2])
        2'd0: begin m_base = {cur[63:32], bmerge(cur[31:0], d, s)}; m_cyc = c; end
        2'd1: begin m_base = {bmerge(cur[63:32], d, s), cur[31:0]}; m_cyc = c; end
        2'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], d, s);
        default: m_cmp[63:32] = bmerge(m_cmp[63:32], d, s);
      endcase
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                    output int h);
    int n;
    @(negedge clk);
    arvalid = 1'b1; araddr = a; n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    h = cyc + 1;
    @(negedge clk);
    arvalid = 1'b0; n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check("r_latency", cyc, h);
    d = rdata; r = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic rd4(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                     output int h);
    int n;
    @(negedge clk);
    arvalid4 = 1'b1; araddr4 = a; n = 0;
    while (!arready4 && n < 20) begin @(negedge clk); n++; end
    h = cyc + 1;
    @(negedge clk);
    arvalid4 = 1'b0; n = 0;
    while (!rvalid4 && n < 20) begin @(negedge clk); n++; end
    check("r4_latency", cyc, h);
    d = rdata4; r = rresp4;
    rready4 = 1'b1;
    @(negedge clk);
    rready4 = 1'b0;
  endtask

  // AW and W presented together: handshake at edge E, commit and bvalid at E+1.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] r, output int c);
    int n;
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    c = cyc + 2;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check("b_latency", cyc, c);
    r = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] exp_resp);
    logic [1:0] r;
    int c;
    wr(a, d, s, r, c);
    check(tag, r, exp_resp);
    note_write(a, d, s, c);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                        input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    int h;
    rd(a, d, r, h);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_resp"}, r, exp_r);
  endtask

  task automatic rd_mtime_lo(input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    logic [63:0] e;
    int h;
    rd(32'h0, d, r, h);
    e = exp_mtime(h - 1);
    m_snap = e[63:32];
    check({tag, "_data"}, d, e[31:0]);
    check({tag, "_resp"}, r, 2'b00);
  endtask

  task automatic check_irq(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check(tag, timer_irq, exp_mtime(cyc - 1) >= m_cmp);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    logic [1:0]  r;
    int h;
    int a_edge;

    rst = 1'b0; arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    rst4 = 1'b0; arvalid4 = 0; rready4 = 0; awvalid4 = 0; wvalid4 = 0; bready4 = 0;
    araddr4 = '0; awaddr4 = '0; wdata4 = '0; wstrb4 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_flags", {arready, awready, wready, rvalid, bvalid, timer_irq}, 6'b111000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resps", {rresp, bresp}, 4'b0000);
    check("rst4_flags", {arready4, awready4, wready4, rvalid4, bvalid4, timer_irq4}, 6'b111000);

    rst = 1'b1; rst4 = 1'b1;
    m_base = '0; m_cyc = cyc; m_cmp = '1; m_snap = '0; base4 = cyc;

    // First read of mtime_lo ten cycles after release, then the hi snapshot
    repeat (9) @(negedge clk);
    check("post_rst_irq", timer_irq, 1'b0);
    rd_mtime_lo("first_lo");
    rd_chk("first_hi", 32'h4, m_snap, 2'b00);

    // Compare at 0x20: irq follows mtime >= mtimecmp one cycle late
    wr_chk("wr_mtime_lo", 32'h0, 32'h0, 4'hF, 2'b00);
    wr_chk("wr_cmp_lo", 32'h8, 32'h20, 4'hF, 2'b00);
    check_irq("irq_cmp_hi_ones", 2);
    wr_chk("wr_cmp_hi", 32'hC, 32'h0, 4'hF, 2'b00);
    check_irq("irq_cmp_0x20", 40);

    // AW alone, W four cycles later, concurrent read of the target register
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'hC;
    @(negedge clk);
    awvalid = 1'b0; a_edge = cyc;
    check("aw_only_awready", awready, 1'b0);
    check("aw_only_wready", wready, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("aw_only_no_b", bvalid, 1'b0);
    end
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    @(negedge clk);
    wvalid = 1'b0;
    check("w_late_no_b", bvalid, 1'b0);
    check("w_late_wready", wready, 1'b0);
    arvalid = 1'b1; araddr = 32'hC;
    @(negedge clk);
    arvalid = 1'b0;
    check("w_late_b", bvalid, 1'b1);
    check("rd_same_cycle_valid", rvalid, 1'b1);
    check("rd_same_cycle_data", rdata, m_cmp[63:32]);
    note_write(32'hC, 32'hFFFF_FFFF, 4'hF, a_edge + 5);
    awvalid = 1'b1; awaddr = 32'h8; rready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      rready = 1'b0;
      check("b_stall_bvalid", bvalid, 1'b1);
      check("b_stall_bresp", bresp, 2'b00);
      check("b_stall_awready", awready, 1'b0);
      check("b_stall_arready", arready, 1'b1);
    end
    awvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done_bvalid", bvalid, 1'b0);
    check("b_done_ready", {awready, wready}, 2'b11);
    rd_chk("cmp_hi_after", 32'hC, m_cmp[63:32], 2'b00);

    // Byte strobes, including an empty strobe
    wr_chk("wr_strb_b1", 32'h8, 32'hAABB_CCDD, 4'b0010, 2'b00);
    rd_chk("cmp_lo_strb", 32'h8, 32'h0000_CC20, 2'b00);
    wr_chk("wr_strb_none", 32'h8, 32'h1234_5678, 4'b0000, 2'b00);
    rd_chk("cmp_lo_nostrb", 32'h8, 32'h0000_CC20, 2'b00);

    // Unmapped accesses
    rd_chk("rd_unaligned", 32'h2, 32'h0, 2'b10);
    wr_chk("wr_past_end", 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b10);
    wr_chk("wr_unaligned", 32'h1, 32'hDEAD_BEEF, 4'hF, 2'b10);
    rd_mtime_lo("unmapped_lo");
    rd_chk("unmapped_hi", 32'h4, m_snap, 2'b00);
    rd_chk("unmapped_cmp_lo", 32'h8, m_cmp[31:0], 2'b00);
    rd_chk("unmapped_cmp_hi", 32'hC, m_cmp[63:32], 2'b00);

    // 64-bit rollover; irq rises at FF..FE and falls once mtime wraps to 0
    wr_chk("wr_hi_ones", 32'h4, 32'hFFFF_FFFF, 4'hF, 2'b00);
    wr_chk("wr_lo_fffe", 32'h0, 32'hFFFF_FFFE, 4'hF, 2'b00);
    check("wrap_irq_pre", timer_irq, exp_mtime(cyc - 1) >= m_cmp);
    check_irq("wrap_irq", 4);
    rd_mtime_lo("wrap_lo");
    rd_chk("wrap_hi_snap", 32'h4, 32'h0, 2'b00);

    // TICK_DIV = 4: reset mid-read, then count in steps of four cycles
    rd4(32'h0, d, r, h);
    check("t4_pre_data", d, exp4(h - 1));
    check("t4_pre_resp", r, 2'b00);
    @(negedge clk);
    arvalid4 = 1'b1; araddr4 = 32'h0;
    @(negedge clk);
    arvalid4 = 1'b0;
    check("t4_mid_rvalid", rvalid4, 1'b1);
    rst4 = 1'b0;
    @(negedge clk);
    check("t4_rst_rvalid", rvalid4, 1'b0);
    check("t4_rst_arready", arready4, 1'b1);
    check("t4_rst_rdata", rdata4, 32'h0);
    rst4 = 1'b1; base4 = cyc;
    for (int i = 0; i < 6; i++) begin
      rd4(32'h0, d, r, h);
      check("t4_mtime", d, exp4(h - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
